// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: ALU control codes, MIPS opcode/funct
// values and the registered issue entry handed to the ALU.
package alu_issue_pkg;

    localparam int ISSUE_DATA_W  = 32;
    localparam int ISSUE_RADDR_W = 5;
    localparam int ISSUE_CTRL_W  = 5;

    // ALU control codes; bit 4 is always zero.
    typedef enum logic [ISSUE_CTRL_W-1:0] {
        ALU_AND = 5'b0_0000,
        ALU_OR  = 5'b0_0001,
        ALU_ADD = 5'b0_0010,
        ALU_SUB = 5'b0_0110
    } alu_ctrl_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;

    typedef struct packed {
        logic [ISSUE_DATA_W-1:0]  data1;
        logic [ISSUE_DATA_W-1:0]  data2;
        alu_ctrl_e                ctrl;
        logic [ISSUE_RADDR_W-1:0] dest;
        logic                     illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decode-side instruction/handshake, bypass inputs, flush and
// the ALU-side operand/handshake outputs. master = surrounding pipeline,
// slave = alu_issue_stage.
interface alu_issue_stage_if
    import alu_issue_pkg::*;
#(
    parameter int DATA_W  = ISSUE_DATA_W,
    parameter int RADDR_W = ISSUE_RADDR_W,
    parameter int CTRL_W  = ISSUE_CTRL_W
);
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [15:0]        imm16;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [RADDR_W-1:0] dest_addr;
    logic               fwd_ex_valid;
    logic [RADDR_W-1:0] fwd_ex_addr;
    logic [DATA_W-1:0]  fwd_ex_data;
    logic               fwd_mem_valid;
    logic [RADDR_W-1:0] fwd_mem_addr;
    logic [DATA_W-1:0]  fwd_mem_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    logic [CTRL_W-1:0]  alu_control;
    logic [RADDR_W-1:0] out_dest;
    logic               illegal;

    modport master (
        output in_valid, opcode, funct, imm16, rs_addr, rt_addr, rs_data, rt_data,
               dest_addr, fwd_ex_valid, fwd_ex_addr, fwd_ex_data, fwd_mem_valid,
               fwd_mem_addr, fwd_mem_data, flush, out_ready,
        input  in_ready, out_valid, data1, data2, alu_control, out_dest, illegal
    );

    modport slave (
        input  in_valid, opcode, funct, imm16, rs_addr, rt_addr, rs_data, rt_data,
               dest_addr, fwd_ex_valid, fwd_ex_addr, fwd_ex_data, fwd_mem_valid,
               fwd_mem_addr, fwd_mem_data, flush, out_ready,
        output in_ready, out_valid, data1, data2, alu_control, out_dest, illegal
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational opcode/funct decode: ALU control code, whether rt supplies the
// second operand, the extended immediate, and the unsupported-instruction flag.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0]              opcode,
    input  logic [5:0]              funct,
    input  logic [15:0]             imm16,
    output alu_ctrl_e               ctrl,
    output logic                    use_rt,
    output logic [ISSUE_DATA_W-1:0] imm_ext,
    output logic                    illegal
);

    logic sign_ext;

    // Arithmetic/address immediates are sign-extended, logical ones zero-extended.
    function automatic logic [ISSUE_DATA_W-1:0] extend_imm(input logic [15:0] imm,
                                                           input logic        sgn);
        logic signed [15:0] imm_s;
        imm_s = imm;
        if (sgn)
            return {{(ISSUE_DATA_W-16){imm_s[15]}}, imm_s};
        else
            return {{(ISSUE_DATA_W-16){1'b0}}, imm};
    endfunction

    // Instruction class decode; anything unrecognised falls back to AND and flags illegal.
    always_comb begin
        ctrl     = ALU_AND;
        use_rt   = 1'b0;
        sign_ext = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rt = 1'b1;
                case (funct)
                    F_AND:         ctrl = ALU_AND;
                    F_OR:          ctrl = ALU_OR;
                    F_ADD, F_ADDU: ctrl = ALU_ADD;
                    F_SUB, F_SUBU: ctrl = ALU_SUB;
                    default:       illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                ctrl     = ALU_ADD;
                sign_ext = 1'b1;
            end
            OP_ANDI: ctrl = ALU_AND;
            OP_ORI:  ctrl = ALU_OR;
            OP_BEQ, OP_BNE: begin
                ctrl   = ALU_SUB;
                use_rt = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl   = ALU_AND;
            use_rt = 1'b0;
        end
    end

    assign imm_ext = extend_imm(imm16, sign_ext);

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage ahead of the ALU: decodes the instruction, selects and
// forwards operands, and registers them behind a valid/ready handshake with
// flush. Define ALU_ISSUE_SKID_EN to add a second (skid) entry and make
// in_ready a registered output.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_W  = ISSUE_DATA_W,
    parameter int RADDR_W = ISSUE_RADDR_W,
    parameter int CTRL_W  = ISSUE_CTRL_W
)(
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave bus
);

    alu_ctrl_e              dec_ctrl;
    logic                   dec_use_rt;
    logic [DATA_W-1:0]      dec_imm;
    logic                   dec_illegal;
    logic [DATA_W-1:0]      rs_val;
    logic [DATA_W-1:0]      rt_val;
    issue_entry_t           next_entry;
    issue_entry_t           out_p0;
    logic                   vld_p0;
    logic                   in_ready_w;
    logic                   load;
    logic                   xfer;

    alu_issue_decode u_decode (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .imm16   (bus.imm16),
        .ctrl    (dec_ctrl),
        .use_rt  (dec_use_rt),
        .imm_ext (dec_imm),
        .illegal (dec_illegal)
    );

    // Register 0 is hard-wired zero; the youngest producer (EX) beats MEM, MEM beats the register file.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [RADDR_W-1:0] addr,
        input logic [DATA_W-1:0]  rf_data,
        input logic               ex_v,
        input logic [RADDR_W-1:0] ex_a,
        input logic [DATA_W-1:0]  ex_d,
        input logic               mem_v,
        input logic [RADDR_W-1:0] mem_a,
        input logic [DATA_W-1:0]  mem_d
    );
        if (addr == '0)
            return '0;
        else if (ex_v && (ex_a == addr))
            return ex_d;
        else if (mem_v && (mem_a == addr))
            return mem_d;
        else
            return rf_data;
    endfunction

    // Build the entry that a load would capture this cycle.
    always_comb begin
        rs_val = pick_operand(bus.rs_addr, bus.rs_data,
                              bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
                              bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);
        rt_val = bus.rt_data;
        if (dec_use_rt)
            rt_val = pick_operand(bus.rt_addr, bus.rt_data,
                                  bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
                                  bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);
        next_entry = '0;
        if (dec_illegal) begin
            next_entry.illegal = 1'b1;
            next_entry.ctrl    = ALU_AND;
        end else begin
            next_entry.data1 = rs_val;
            next_entry.data2 = dec_use_rt ? rt_val : dec_imm;
            next_entry.ctrl  = dec_ctrl;
            next_entry.dest  = bus.dest_addr;
        end
    end

    assign xfer = vld_p0 && bus.out_ready;
    assign load = bus.in_valid && in_ready_w;

`ifdef ALU_ISSUE_SKID_EN
    issue_entry_t skid_p1;
    logic         skid_vld_p1;

    assign in_ready_w = !skid_vld_p1;

    // Output entry plus skid: the skid refills the output on transfer, so order is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0      <= 1'b0;
            out_p0      <= '0;
            skid_vld_p1 <= 1'b0;
            skid_p1     <= '0;
        end else if (bus.flush) begin
            vld_p0      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (xfer) begin
            if (skid_vld_p1) begin
                out_p0      <= skid_p1;
                skid_vld_p1 <= 1'b0;
            end else if (load) begin
                out_p0 <= next_entry;
            end else begin
                vld_p0 <= 1'b0;
            end
        end else if (load) begin
            if (vld_p0) begin
                skid_p1     <= next_entry;
                skid_vld_p1 <= 1'b1;
            end else begin
                out_p0 <= next_entry;
                vld_p0 <= 1'b1;
            end
        end
    end
`else
    assign in_ready_w = !vld_p0 || bus.out_ready;

    // Single output entry: load when ready, hold while stalled, drop valid on a bare transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            out_p0 <= '0;
        end else if (bus.flush) begin
            vld_p0 <= 1'b0;
        end else if (load) begin
            vld_p0 <= 1'b1;
            out_p0 <= next_entry;
        end else if (xfer) begin
            vld_p0 <= 1'b0;
        end
    end
`endif

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = vld_p0;
    assign bus.data1       = out_p0.data1;
    assign bus.data2       = out_p0.data2;
    assign bus.alu_control = CTRL_W'(out_p0.ctrl);
    assign bus.out_dest    = out_p0.dest;
    assign bus.illegal     = out_p0.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: table of decode/forwarding vectors
// streamed back-to-back, then stall, flush, async reset and (with
// ALU_ISSUE_SKID_EN) skid ordering sequences.
module tb_alu_issue_stage;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  dst;
        logic        exv;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        memv;
        logic [4:0]  mema;
        logic [31:0] memd;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic [4:0]  e_ctrl;
        logic [4:0]  e_dest;
        logic        e_ill;
    } vec_t;

    localparam int NV = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [NV];

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] snap();
        return {4'b0, bus.out_valid, bus.illegal, bus.out_dest, bus.alu_control,
                bus.data1, bus.data2};
    endfunction

    function automatic logic [79:0] expect_of(input vec_t v);
        return {4'b0, 1'b1, v.e_ill, v.e_dest, v.e_ctrl, v.e_d1, v.e_d2};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v);
        bus.opcode        = v.op;
        bus.funct         = v.fn;
        bus.imm16         = v.imm;
        bus.rs_addr       = v.rsa;
        bus.rt_addr       = v.rta;
        bus.rs_data       = v.rsd;
        bus.rt_data       = v.rtd;
        bus.dest_addr     = v.dst;
        bus.fwd_ex_valid  = v.exv;
        bus.fwd_ex_addr   = v.exa;
        bus.fwd_ex_data   = v.exd;
        bus.fwd_mem_valid = v.memv;
        bus.fwd_mem_addr  = v.mema;
        bus.fwd_mem_data  = v.memd;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //          op     fn     imm       rsa   rta   rsd           rtd       dst    exv  exa   exd         memv mema  memd      e_d1          e_d2          ctrl   dest   ill
        vecs[0]  = '{6'h00, 6'h20, 16'h0000, 5'd1, 5'd2, 32'd5,        32'd7,    5'd3,  1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,    32'd5,        32'd7,        5'h02, 5'd3,  1'b0};
        vecs[1]  = '{6'h08, 6'h00, 16'hFFFF, 5'd1, 5'd2, 32'd10,       32'd99,   5'd4,  1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,    32'd10,       32'hFFFFFFFF, 5'h02, 5'd4,  1'b0};
        vecs[2]  = '{6'h0D, 6'h00, 16'hFFFF, 5'd1, 5'd2, 32'd10,       32'd99,   5'd5,  1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,    32'd10,       32'h0000FFFF, 5'h01, 5'd5,  1'b0};
        vecs[3]  = '{6'h00, 6'h22, 16'h0000, 5'd3, 5'd4, 32'd1,        32'd2,    5'd6,  1'b1, 5'd3, 32'hAA,     1'b1, 5'd3, 32'hBB,   32'hAA,       32'd2,        5'h06, 5'd6,  1'b0};
        vecs[4]  = '{6'h00, 6'h25, 16'h0000, 5'd5, 5'd6, 32'h11,       32'h22,   5'd7,  1'b1, 5'd7, 32'hCC,     1'b1, 5'd6, 32'hBB,   32'h11,       32'hBB,       5'h01, 5'd7,  1'b0};
        vecs[5]  = '{6'h00, 6'h24, 16'h0000, 5'd0, 5'd2, 32'h55,       32'h0F,   5'd8,  1'b1, 5'd0, 32'hAA,     1'b1, 5'd0, 32'hBB,   32'h0,        32'h0F,       5'h00, 5'd8,  1'b0};
        vecs[6]  = '{6'h0C, 6'h00, 16'h8001, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h3,    5'd9,  1'b1, 5'd2, 32'hAA,     1'b0, 5'd0, 32'h0,    32'hFFFFFFFF, 32'h00008001, 5'h00, 5'd9,  1'b0};
        vecs[7]  = '{6'h23, 6'h00, 16'h8000, 5'd9, 5'd2, 32'h1000,     32'h0,    5'd10, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,    32'h1000,     32'hFFFF8000, 5'h02, 5'd10, 1'b0};
        vecs[8]  = '{6'h2B, 6'h00, 16'h0010, 5'd9, 5'd2, 32'h1000,     32'h0,    5'd11, 1'b1, 5'd9, 32'h2000,   1'b0, 5'd0, 32'h0,    32'h2000,     32'h10,       5'h02, 5'd11, 1'b0};
        vecs[9]  = '{6'h04, 6'h00, 16'h0003, 5'd1, 5'd2, 32'd3,        32'd4,    5'd0,  1'b1, 5'd2, 32'h77,     1'b0, 5'd0, 32'h0,    32'd3,        32'h77,       5'h06, 5'd0,  1'b0};
        vecs[10] = '{6'h00, 6'h2A, 16'h0000, 5'd1, 5'd2, 32'd5,        32'd7,    5'd3,  1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,    32'h0,        32'h0,        5'h00, 5'd0,  1'b1};
        vecs[11] = '{6'h3F, 6'h20, 16'h1234, 5'd1, 5'd2, 32'd5,        32'd7,    5'd3,  1'b1, 5'd1, 32'h9,      1'b0, 5'd0, 32'h0,    32'h0,        32'h0,        5'h00, 5'd0,  1'b1};
        vecs[12] = '{6'h00, 6'h21, 16'h0000, 5'd4, 5'd5, 32'h1,        32'h2,    5'd12, 1'b1, 5'd5, 32'h66,     1'b1, 5'd4, 32'h44,   32'h44,       32'h66,       5'h02, 5'd12, 1'b0};
        vecs[13] = '{6'h09, 6'h00, 16'h7FFF, 5'd1, 5'd2, 32'h1,        32'h2,    5'd13, 1'b0, 5'd1, 32'hDEAD,   1'b0, 5'd1, 32'hBEEF, 32'h1,        32'h00007FFF, 5'h02, 5'd13, 1'b0};
        vecs[14] = '{6'h00, 6'h23, 16'h0000, 5'd1, 5'd2, 32'd9,        32'd4,    5'd14, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,    32'd9,        32'd4,        5'h06, 5'd14, 1'b0};
        vecs[15] = '{6'h05, 6'h00, 16'h0000, 5'd1, 5'd2, 32'd8,        32'd8,    5'd0,  1'b0, 5'd0, 32'h0,      1'b1, 5'd1, 32'h31,   32'h31,       32'd8,        5'h06, 5'd0,  1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        set_vec(vecs[0]);
        repeat (3) step();
        chk("reset_outputs", snap(), 80'h0);
        chk("reset_in_ready", {79'h0, bus.in_ready}, 80'h1);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", snap(), 80'h0);

        // Back-to-back stream: every cycle transfers out and loads in.
        for (int i = 0; i < NV; i++) begin
            set_vec(vecs[i]);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            step();
            chk($sformatf("vec%0d", i), snap(), expect_of(vecs[i]));
            chk($sformatf("vec%0d_in_ready", i), {79'h0, bus.in_ready}, 80'h1);
        end

        // Transfer with nothing new drops valid.
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", {79'h0, bus.out_valid}, 80'h0);

`ifdef ALU_ISSUE_SKID_EN
        // Two accepts while the consumer stalls: one in the output, one parked in the skid.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_vec(vecs[0]);
        step();
        chk("skid_first", snap(), expect_of(vecs[0]));
        chk("skid_first_ready", {79'h0, bus.in_ready}, 80'h1);
        set_vec(vecs[1]);
        step();
        chk("skid_park_hold", snap(), expect_of(vecs[0]));
        chk("skid_full_ready", {79'h0, bus.in_ready}, 80'h0);
        set_vec(vecs[2]);
        step();
        chk("skid_full_hold", snap(), expect_of(vecs[0]));
        chk("skid_full_ready2", {79'h0, bus.in_ready}, 80'h0);
        bus.out_ready = 1'b1;
        step();
        chk("skid_drain_second", snap(), expect_of(vecs[1]));
        chk("skid_ready_again", {79'h0, bus.in_ready}, 80'h1);
        step();
        chk("skid_drain_third", snap(), expect_of(vecs[2]));
        bus.in_valid = 1'b0;
        step();
        chk("skid_empty", {79'h0, bus.out_valid}, 80'h0);
`else
        // Stall: output holds and in_ready stays low while out_ready is low.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_vec(vecs[0]);
        step();
        chk("stall_load", snap(), expect_of(vecs[0]));
        set_vec(vecs[1]);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall_hold%0d", c), snap(), expect_of(vecs[0]));
            chk($sformatf("stall_ready%0d", c), {79'h0, bus.in_ready}, 80'h0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("stall_release", snap(), expect_of(vecs[1]));
        bus.in_valid = 1'b0;
        step();
        chk("stall_drain", {79'h0, bus.out_valid}, 80'h0);
`endif

        // Flush beats a held entry and a same-cycle load.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_vec(vecs[3]);
        step();
        chk("flush_pre", snap(), expect_of(vecs[3]));
        set_vec(vecs[4]);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        step();
        chk("flush_valid", {79'h0, bus.out_valid}, 80'h0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("flush_stays_empty", {79'h0, bus.out_valid}, 80'h0);

        // Asynchronous reset in the middle of a stream clears outputs without a clock edge.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_vec(vecs[12]);
        step();
        chk("rst_pre", snap(), expect_of(vecs[12]));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", snap(), 80'h0);
        step();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("post_reset_idle", snap(), 80'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Execute-issue pipeline stage directly upstream of the ALU. It decodes opcode/funct into the ALU control code, builds both operands, applies EX/MEM result forwarding, and registers the result for the ALU with a valid/ready handshake plus stall and flush. Its registered outputs drive the ALU's data1, data2 and aluControl inputs unchanged.

Parameters:
DATA_W, 32, operand width
RADDR_W, 5, register-address width
CTRL_W, 5, ALU control width (codes occupy bits [3:0], bit 4 always 0)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode stage presents an instruction
in_ready  out  1  stage can accept
opcode  in  6  instruction [31:26]
funct  in  6  instruction [5:0]
imm16  in  16  instruction [15:0]
rs_addr / rt_addr  in  RADDR_W  source registers
rs_data / rt_data  in  DATA_W  register-file read data
dest_addr  in  RADDR_W  destination register
fwd_ex_valid, fwd_ex_addr, fwd_ex_data  in  1/RADDR_W/DATA_W  EX result bypass
fwd_mem_valid, fwd_mem_addr, fwd_mem_data  in  1/RADDR_W/DATA_W  MEM result bypass
flush  in  1  kill the held and incoming instruction
out_valid  out  1  ALU operands valid
out_ready  in  1  ALU/EX consumer accepts
data1 / data2  out  DATA_W  ALU operands
alu_control  out  CTRL_W  ALU operation
out_dest  out  RADDR_W  destination, passed through
illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (async assert, sync release): out_valid=0, data1=data2=0, alu_control=0, out_dest=0, illegal=0.
- Codes: AND 0_0000, OR 0_0001, ADD 0_0010, SUB 0_0110. No other values are emitted.
- Decode, R-type (opcode 0x00): funct 0x24 AND; 0x25 OR; 0x20/0x21 ADD; 0x22/0x23 SUB; operands rs, rt.
- Decode, I-type: 0x08/0x09 ADD with sign-extended imm16; 0x0C AND and 0x0D OR with zero-extended imm16; 0x23/0x2B ADD with sign-extended imm16 (address); 0x04/0x05 SUB with rs, rt.
- Any other opcode or funct: illegal=1, alu_control=AND, data1=data2=0, out_dest=0.
- Operand source: address 0 always reads as 0 and is never forwarded. Otherwise EX match (valid && addr equal) wins over MEM match, and MEM match wins over register-file data. Forwarding applies to rs, and to rt only when rt is used.
- Handshake: in_ready = !out_valid || out_ready. A load occurs on in_valid && in_ready, with 1-cycle latency to out_valid. If out_valid && !out_ready, all outputs hold stable. A transfer out with no load clears out_valid.
- Flush: out_valid=0 next cycle and any same-cycle load is discarded. Flush wins over every other event. Data registers may hold stale values while out_valid=0.
- Back-to-back: a simultaneous transfer out and load in gives full throughput with no bubble.

Optional Feature:
ALU_ISSUE_SKID_EN
- Defined: a second skid entry is added and in_ready becomes a registered output (in_ready = !skid_full). An acceptance while out_valid && !out_ready parks in the skid. The skid entry moves to the output on the next transfer. Order is preserved. Flush empties both entries.
- Undefined: single entry with combinational in_ready as above.

Decomposition:
- Package alu_issue_pkg: alu_ctrl_e enum (AND/OR/ADD/SUB), opcode and funct localparams, and the packed issue_entry_t struct (data1, data2, ctrl, dest, illegal).
- One sub-module: alu_issue_decode. It is combinational and maps opcode/funct/imm16 to ctrl, operand-select, extension type and illegal. The forwarding mux and registers stay in the top.

Test Plan:
- R-type ADD: opcode 0, funct 0x20, rs_data=5, rt_data=7, no forwarding -> next cycle out_valid=1, data1=5, data2=7, alu_control=0x02.
- ADDI imm16=0xFFFF, rs_data=10 -> data2=0xFFFFFFFF, ctrl=0x02. ORI imm16=0xFFFF -> data2=0x0000FFFF, ctrl=0x01.
- Forward priority: rs_addr=3, EX(3,0xAA) and MEM(3,0xBB) both valid -> data1=0xAA. rs_addr=0 with EX(0,0xAA) -> data1=0.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged. out_ready=1 -> next instruction loaded without a bubble.
- Flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0. rst_n pulsed low mid-stream -> all outputs 0 immediately.
- Illegal funct 0x2A -> illegal=1, ctrl=0x00, data1=data2=0. With ALU_ISSUE_SKID_EN: two accepts while out_ready=0 -> in_ready=0, and both drain in order.
